// File: rtl/mc_control_unit_pkg.sv
// mc_control_unit_pkg: TSC ISA opcodes/funcs, ALU opcodes, datapath select codes and FSM states.
package mc_control_unit_pkg;
   localparam logic [3:0] OPC_BNE = 4'd0;
   localparam logic [3:0] OPC_BEQ = 4'd1;
   localparam logic [3:0] OPC_BGZ = 4'd2;
   localparam logic [3:0] OPC_BLZ = 4'd3;
   localparam logic [3:0] OPC_ADI = 4'd4;
   localparam logic [3:0] OPC_ORI = 4'd5;
   localparam logic [3:0] OPC_LHI = 4'd6;
   localparam logic [3:0] OPC_LWD = 4'd7;
   localparam logic [3:0] OPC_SWD = 4'd8;
   localparam logic [3:0] OPC_JMP = 4'd9;
   localparam logic [3:0] OPC_JAL = 4'd10;
   localparam logic [3:0] OPC_RTY = 4'd15;

   localparam logic [5:0] FN_ADD = 6'd0;
   localparam logic [5:0] FN_SUB = 6'd1;
   localparam logic [5:0] FN_AND = 6'd2;
   localparam logic [5:0] FN_ORR = 6'd3;
   localparam logic [5:0] FN_NOT = 6'd4;
   localparam logic [5:0] FN_TCP = 6'd5;
   localparam logic [5:0] FN_SHL = 6'd6;
   localparam logic [5:0] FN_SHR = 6'd7;
   localparam logic [5:0] FN_JPR = 6'd25;
   localparam logic [5:0] FN_JRL = 6'd26;
   localparam logic [5:0] FN_WWD = 6'd28;
   localparam logic [5:0] FN_HLT = 6'd29;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_ID  = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_ALS = 4'd6;
   localparam logic [3:0] OP_ARS = 4'd7;
   localparam logic [3:0] OP_LHI = 4'd8;

   localparam logic [1:0] SA_PC   = 2'd0;
   localparam logic [1:0] SA_RS   = 2'd1;
   localparam logic [1:0] SA_ZERO = 2'd2;
   localparam logic [2:0] SB_RT   = 3'd0;
   localparam logic [2:0] SB_SEXT = 3'd1;
   localparam logic [2:0] SB_ONE  = 3'd2;
   localparam logic [2:0] SB_ZEXT = 3'd3;
   localparam logic [2:0] SB_RS   = 3'd4;

   localparam logic [1:0] PCS_ALU = 2'd0;
   localparam logic [1:0] PCS_JMP = 2'd1;
   localparam logic [1:0] PCS_RS  = 2'd2;
   localparam logic [1:0] RD_RT   = 2'd0;
   localparam logic [1:0] RD_RD   = 2'd1;
   localparam logic [1:0] RD_R2   = 2'd2;
   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_MDR  = 2'd1;
   localparam logic [1:0] WB_PC   = 2'd2;

   typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_e;

   // Successor of EX: ALU results need WB, memory ops need MEM, everything else retires.
   function automatic state_e ex_next(input logic [3:0] opc, input logic [5:0] fn);
      if ((opc == OPC_RTY && fn[5:3] == 3'd0) || opc == OPC_ADI || opc == OPC_ORI || opc == OPC_LHI)
         return S_WB;
      if (opc == OPC_LWD || opc == OPC_SWD)
         return S_MEM;
      return S_IF;
   endfunction
endpackage

// File: rtl/mc_control_unit_alu_op_decode.sv
// mc_control_unit_alu_op_decode: ALU opcode and operand selects from FSM state and instruction.
module mc_control_unit_alu_op_decode
   import mc_control_unit_pkg::*;
(
   input  state_e     state_i,
   input  logic [3:0] opcode_i,
   input  logic [5:0] func_i,
   output logic [3:0] alu_op_o,
   output logic [1:0] alu_src_a_o,
   output logic [2:0] alu_src_b_o
);
   always_comb begin
      alu_op_o    = OP_ADD;
      alu_src_a_o = SA_PC;
      alu_src_b_o = SB_RT;
      if (state_i == S_ID) begin
         alu_src_b_o = SB_ONE;
      end else if (state_i == S_EX) begin
         case (opcode_i)
            OPC_BNE, OPC_BEQ, OPC_BGZ, OPC_BLZ: alu_src_b_o = SB_SEXT;
            OPC_ADI, OPC_LWD, OPC_SWD: begin
               alu_src_a_o = SA_RS;
               alu_src_b_o = SB_SEXT;
            end
            OPC_ORI: begin
               alu_op_o    = OP_OR;
               alu_src_a_o = SA_RS;
               alu_src_b_o = SB_ZEXT;
            end
            OPC_LHI: begin
               alu_op_o    = OP_LHI;
               alu_src_b_o = SB_ZEXT;
            end
            OPC_RTY: begin
               case (func_i)
                  FN_ADD: alu_src_a_o = SA_RS;
                  FN_SUB: begin alu_op_o = OP_SUB; alu_src_a_o = SA_RS; end
                  FN_AND: begin alu_op_o = OP_AND; alu_src_a_o = SA_RS; end
                  FN_ORR: begin alu_op_o = OP_OR;  alu_src_a_o = SA_RS; end
                  FN_NOT: begin alu_op_o = OP_NOT; alu_src_a_o = SA_RS; end
                  FN_SHL: begin alu_op_o = OP_ALS; alu_src_a_o = SA_RS; end
                  FN_SHR: begin alu_op_o = OP_ARS; alu_src_a_o = SA_RS; end
                  FN_WWD: begin alu_op_o = OP_ID;  alu_src_a_o = SA_RS; end
                  FN_TCP: begin
                     alu_op_o    = OP_SUB;
                     alu_src_a_o = SA_ZERO;
                     alu_src_b_o = SB_RS;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle TSC control FSM (IF/ID/EX/MEM/WB/HALT) with strobe decode
// and retired-instruction counter.
module mc_control_unit
   import mc_control_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] instr,
   input  logic        mem_ready,
   input  logic        cond_true,
   output logic [3:0]  alu_op,
   output logic        alu_cin,
   output logic [1:0]  alu_src_a,
   output logic [2:0]  alu_src_b,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        ir_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        i_or_d,
   output logic        reg_write,
   output logic [1:0]  reg_dst,
   output logic [1:0]  wb_src,
   output logic        output_port_en,
   output logic        is_halted,
   output logic [15:0] num_inst
);
   state_e      state_q, state_d;
   logic [15:0] num_inst_q, num_inst_d;
   logic        retire, link, is_hlt, is_lwd;
   logic [3:0]  opc;
   logic [5:0]  fn;
   logic        unused_fields;

   assign opc           = instr[15:12];
   assign fn            = instr[5:0];
   assign unused_fields = ^instr[11:6];
   assign is_hlt        = opc == OPC_RTY && fn == FN_HLT;
   assign is_lwd        = opc == OPC_LWD;

   mc_control_unit_alu_op_decode u_alu_op_decode (
      .state_i     (state_q),
      .opcode_i    (opc),
      .func_i      (fn),
      .alu_op_o    (alu_op),
      .alu_src_a_o (alu_src_a),
      .alu_src_b_o (alu_src_b)
   );

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_IF:  state_d = mem_ready ? S_ID : S_IF;
         S_ID: begin
            state_d = is_hlt ? S_HALT : S_EX;
            retire  = is_hlt;
         end
         S_EX: begin
            state_d = ex_next(opc, fn);
            retire  = ex_next(opc, fn) == S_IF;
         end
         S_MEM: begin
            state_d = mem_ready ? (is_lwd ? S_WB : S_IF) : S_MEM;
            retire  = mem_ready && !is_lwd;
         end
         S_WB: begin
            state_d = S_IF;
            retire  = 1'b1;
         end
         default: state_d = S_HALT;
      endcase
      num_inst_d = num_inst_q + {15'd0, retire};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IF;
         num_inst_q <= '0;
      end else begin
         state_q    <= state_d;
         num_inst_q <= num_inst_d;
      end
   end

   // Reset forces the state to IF asynchronously, so only the IF strobes need gating.
   always_comb begin
      pc_write       = 1'b0;
      pc_src         = PCS_ALU;
      ir_write       = 1'b0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      i_or_d         = 1'b0;
      reg_write      = 1'b0;
      reg_dst        = RD_RT;
      wb_src         = WB_ALU;
      output_port_en = 1'b0;
      link           = 1'b0;
      case (state_q)
         S_IF: begin
            mem_read = reset_n;
            ir_write = reset_n && mem_ready;
         end
         S_ID: pc_write = 1'b1;
         S_EX: begin
            case (opc)
               OPC_BNE, OPC_BEQ, OPC_BGZ, OPC_BLZ: pc_write = cond_true;
               OPC_JMP, OPC_JAL: begin
                  pc_write = 1'b1;
                  pc_src   = PCS_JMP;
                  link     = opc == OPC_JAL;
               end
               OPC_RTY: begin
                  pc_write       = fn == FN_JPR || fn == FN_JRL;
                  pc_src         = (fn == FN_JPR || fn == FN_JRL) ? PCS_RS : PCS_ALU;
                  link           = fn == FN_JRL;
                  output_port_en = fn == FN_WWD;
               end
               default: ;
            endcase
            reg_write = link;
            reg_dst   = link ? RD_R2 : RD_RT;
            wb_src    = link ? WB_PC : WB_ALU;
         end
         S_MEM: begin
            mem_read  = is_lwd;
            mem_write = !is_lwd;
            i_or_d    = 1'b1;
         end
         S_WB: begin
            reg_write = 1'b1;
            reg_dst   = opc == OPC_RTY ? RD_RD : RD_RT;
            wb_src    = is_lwd ? WB_MDR : WB_ALU;
         end
         default: ;
      endcase
   end

   assign alu_cin   = 1'b0;
   assign is_halted = state_q == S_HALT;
   assign num_inst  = num_inst_q;
endmodule
